// File: rtl/grid_cursor_pkg.sv
// Shared types for the grid cursor: button direction decode and repeat FSM states.
package grid_cursor_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RPT
    } rpt_state_t;

    // btn = {up, down, left, right}; anything other than one-hot is no command.
    function automatic dir_t decode_dir(input logic [3:0] btn);
        case (btn)
            4'b1000: decode_dir = DIR_UP;
            4'b0100: decode_dir = DIR_DOWN;
            4'b0010: decode_dir = DIR_LEFT;
            4'b0001: decode_dir = DIR_RIGHT;
            default: decode_dir = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/grid_cursor_gen_if.sv
// Cursor bus: debounced direction buttons and cell mask in, cursor position and
// event pulses out.
//   master: drives buttons/restriction/forbid_mask, observes pos_x/pos_y/val/moved/blocked
//   slave : the cursor generator
interface grid_cursor_gen_if #(
    parameter int COLS = 6,
    parameter int ROWS = 4
);
    localparam int X_W   = $clog2(COLS);
    localparam int Y_W   = $clog2(ROWS);
    localparam int IDX_W = $clog2(COLS*ROWS);

    logic                 restriction;
    logic [COLS*ROWS-1:0] forbid_mask;
    logic                 dir_up;
    logic                 dir_down;
    logic                 dir_left;
    logic                 dir_right;
    logic [X_W-1:0]       pos_x;
    logic [Y_W-1:0]       pos_y;
    logic [IDX_W-1:0]     val;
    logic                 moved;
    logic                 blocked;

    modport master (
        output restriction, forbid_mask, dir_up, dir_down, dir_left, dir_right,
        input  pos_x, pos_y, val, moved, blocked
    );

    modport slave (
        input  restriction, forbid_mask, dir_up, dir_down, dir_left, dir_right,
        output pos_x, pos_y, val, moved, blocked
    );

endinterface

// File: rtl/key_repeat.sv
// Button edge detect plus hold-to-repeat FSM.
//   clk, rst : clock, synchronous active-low reset
//   btn      : {up, down, left, right}, debounced levels
//   step     : 1 in each cycle a cursor step is requested
//   dir      : decoded direction of btn (valid when step=1)
module key_repeat
    import grid_cursor_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       step,
    output dir_t       dir
);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

    rpt_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       btn_q;
    logic             one_hot;
    logic             changed;

    assign one_hot = $onehot(btn);
    assign changed = (btn != btn_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            btn_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            btn_q <= btn;
        end
    end

    // A change of button pattern restarts from IDLE behaviour in any state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!one_hot) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (changed) begin
            state_nxt = HOLD;
            cnt_nxt   = DELAY_LD;
        end else begin
            case (state)
                HOLD, RPT: begin
                    if (cnt == '0) begin
                        state_nxt = RPT;
                        cnt_nxt   = RATE_LD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        step = 1'b0;
        dir  = decode_dir(btn);
        if (one_hot) begin
            if (changed)
                step = 1'b1;
            else if (state != IDLE && cnt == '0)
                step = 1'b1;
        end
    end

endmodule

// File: rtl/grid_cursor_gen.sv
// Grid cursor: moves (x,y) over a COLS x ROWS grid from direction buttons,
// skipping forbidden cells, with wrap or clamp at the edges.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of grid_cursor_gen_if (buttons/mask in, position/pulses out)
module grid_cursor_gen
    import grid_cursor_pkg::*;
#(
    parameter int COLS         = 6,
    parameter int ROWS         = 4,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int WRAP         = 1
) (
    input  logic               clk,
    input  logic               rst,
    grid_cursor_gen_if.slave   bus
);
    localparam int X_W   = $clog2(COLS);
    localparam int Y_W   = $clog2(ROWS);
    localparam int IDX_W = $clog2(COLS*ROWS);
    localparam int MAXN  = (COLS > ROWS) ? COLS : ROWS;
    localparam logic [X_W:0] XLAST = (X_W+1)'(COLS - 1);
    localparam logic [Y_W:0] YLAST = (Y_W+1)'(ROWS - 1);

    logic [3:0]       btn;
    logic             step;
    dir_t             dir;
    logic [X_W-1:0]   pos_x, tx;
    logic [Y_W-1:0]   pos_y, ty;
    logic [IDX_W-1:0] val, val_nxt, cur_idx;
    logic             moved, blocked;
    logic             found, alive, axis_x, inc, snap;
    logic [X_W:0]     cx;
    logic [Y_W:0]     cy;
    logic [IDX_W:0]   idx_full;
    int               n_axis;

    assign btn = {bus.dir_up, bus.dir_down, bus.dir_left, bus.dir_right};

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rpt (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .step (step),
        .dir  (dir)
    );

    assign axis_x  = (dir == DIR_LEFT) || (dir == DIR_RIGHT);
    assign inc     = (dir == DIR_RIGHT) || (dir == DIR_DOWN);
    assign n_axis  = axis_x ? COLS : ROWS;
    assign cur_idx = IDX_W'((IDX_W+1)'(pos_y) * (IDX_W+1)'(COLS) + (IDX_W+1)'(pos_x));
    assign snap    = bus.restriction && bus.forbid_mask[cur_idx];

    // Walk one cell at a time along the axis; the first allowed cell wins.
    // Clamp mode kills the walk at the grid edge instead of wrapping.
    always_comb begin
        found    = 1'b0;
        alive    = 1'b1;
        cx       = {1'b0, pos_x};
        cy       = {1'b0, pos_y};
        tx       = pos_x;
        ty       = pos_y;
        idx_full = '0;
        for (int k = 1; k < MAXN; k++) begin
            if (alive && !found && k < n_axis) begin
                if (axis_x) begin
                    if (inc) begin
                        if (cx == XLAST) begin
                            if (WRAP != 0) cx = '0;
                            else           alive = 1'b0;
                        end else cx = cx + 1'b1;
                    end else begin
                        if (cx == '0) begin
                            if (WRAP != 0) cx = XLAST;
                            else           alive = 1'b0;
                        end else cx = cx - 1'b1;
                    end
                end else begin
                    if (inc) begin
                        if (cy == YLAST) begin
                            if (WRAP != 0) cy = '0;
                            else           alive = 1'b0;
                        end else cy = cy + 1'b1;
                    end else begin
                        if (cy == '0) begin
                            if (WRAP != 0) cy = YLAST;
                            else           alive = 1'b0;
                        end else cy = cy - 1'b1;
                    end
                end
                if (alive) begin
                    idx_full = (IDX_W+1)'(cy) * (IDX_W+1)'(COLS) + (IDX_W+1)'(cx);
                    if (!(bus.restriction && bus.forbid_mask[idx_full[IDX_W-1:0]])) begin
                        found = 1'b1;
                        tx    = cx[X_W-1:0];
                        ty    = cy[Y_W-1:0];
                    end
                end
            end
        end
    end

    assign val_nxt = IDX_W'((IDX_W+1)'(ty) * (IDX_W+1)'(COLS) + (IDX_W+1)'(tx));

    // Snap to (0,0) wins over any step requested in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_x   <= '0;
            pos_y   <= '0;
            val     <= '0;
            moved   <= 1'b0;
            blocked <= 1'b0;
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            if (snap) begin
                pos_x <= '0;
                pos_y <= '0;
                val   <= '0;
                moved <= 1'b1;
            end else if (step) begin
                if (found) begin
                    pos_x <= tx;
                    pos_y <= ty;
                    val   <= val_nxt;
                    moved <= 1'b1;
                end else begin
                    blocked <= 1'b1;
                end
            end
        end
    end

    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.val     = val;
    assign bus.moved   = moved;
    assign bus.blocked = blocked;

endmodule

// File: tb/tb_grid_cursor_gen.sv
module tb_grid_cursor_gen;
    import grid_cursor_pkg::*;

    localparam logic [3:0] B_U = 4'b1000;
    localparam logic [3:0] B_D = 4'b0100;
    localparam logic [3:0] B_L = 4'b0010;
    localparam logic [3:0] B_R = 4'b0001;
    localparam logic [3:0] B_0 = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  btn = '0;
    logic        restr = 1'b0;
    logic [23:0] mask = '0;
    int          n_chk = 0;
    int          n_err = 0;

    grid_cursor_gen_if #(.COLS(6), .ROWS(4)) bw ();
    grid_cursor_gen_if #(.COLS(6), .ROWS(4)) bc ();

    assign {bw.dir_up, bw.dir_down, bw.dir_left, bw.dir_right} = btn;
    assign {bc.dir_up, bc.dir_down, bc.dir_left, bc.dir_right} = btn;
    assign bw.restriction = restr;
    assign bc.restriction = restr;
    assign bw.forbid_mask = mask;
    assign bc.forbid_mask = mask;

    grid_cursor_gen #(.COLS(6), .ROWS(4), .REPEAT_DELAY(8), .REPEAT_RATE(3), .WRAP(1))
        dut_w (.clk(clk), .rst(rst), .bus(bw));
    grid_cursor_gen #(.COLS(6), .ROWS(4), .REPEAT_DELAY(8), .REPEAT_RATE(3), .WRAP(0))
        dut_c (.clk(clk), .rst(rst), .bus(bc));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] b;
        int         ex;
        int         ey;
        int         em;
        int         eb;
    } vec_t;

    vec_t tv[24];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input int ex, input int ey, input int em, input int eb);
        chk({nm, ".x"}, int'(bw.pos_x), ex);
        chk({nm, ".y"}, int'(bw.pos_y), ey);
        chk({nm, ".val"}, int'(bw.val), ey*6 + ex);
        chk({nm, ".moved"}, int'(bw.moved), em);
        chk({nm, ".blocked"}, int'(bw.blocked), eb);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] b);
        btn = b;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn = B_0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        int y;
        logic [23:0] m3;
        m3 = '0;
        m3[14] = 1'b1; m3[15] = 1'b1; m3[18] = 1'b1;
        m3[19] = 1'b1; m3[20] = 1'b1; m3[21] = 1'b1;

        tv[0]  = '{B_R, 1, 0, 1, 0};  tv[1]  = '{B_0, 1, 0, 0, 0};
        tv[2]  = '{B_R, 2, 0, 1, 0};  tv[3]  = '{B_0, 2, 0, 0, 0};
        tv[4]  = '{B_R, 3, 0, 1, 0};  tv[5]  = '{B_0, 3, 0, 0, 0};
        tv[6]  = '{B_R, 4, 0, 1, 0};  tv[7]  = '{B_0, 4, 0, 0, 0};
        tv[8]  = '{B_R, 5, 0, 1, 0};  tv[9]  = '{B_0, 5, 0, 0, 0};
        tv[10] = '{B_R, 0, 0, 1, 0};  tv[11] = '{B_0, 0, 0, 0, 0};
        tv[12] = '{B_R, 1, 0, 1, 0};  tv[13] = '{B_0, 1, 0, 0, 0};
        tv[14] = '{B_L, 0, 0, 1, 0};  tv[15] = '{B_0, 0, 0, 0, 0};
        tv[16] = '{B_L, 5, 0, 1, 0};  tv[17] = '{B_0, 5, 0, 0, 0};
        tv[18] = '{B_U, 5, 3, 1, 0};  tv[19] = '{B_0, 5, 3, 0, 0};
        tv[20] = '{B_D, 5, 0, 1, 0};  tv[21] = '{B_0, 5, 0, 0, 0};
        tv[22] = '{B_R | B_L, 5, 0, 0, 0};
        tv[23] = '{B_0, 5, 0, 0, 0};

        // reset state
        do_reset();
        chk_w("reset", 0, 0, 0, 0);
        chk("reset.state", int'(dut_w.u_rpt.state), int'(IDLE));

        // single taps, wrap at edges
        for (int i = 0; i < 24; i++) begin
            apply(tv[i].b);
            chk_w($sformatf("vec%0d", i), tv[i].ex, tv[i].ey, tv[i].em, tv[i].eb);
        end

        // hold down: steps at c0, c8, c11, c14, c17
        do_reset();
        y = 0;
        btn = B_D;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (c == 0 || c == 8 || c == 11 || c == 14 || c == 17) begin
                y = (y + 1) % 4;
                chk($sformatf("hold.c%0d.moved", c), int'(bw.moved), 1);
            end else begin
                chk($sformatf("hold.c%0d.moved", c), int'(bw.moved), 0);
            end
            chk($sformatf("hold.c%0d.y", c), int'(bw.pos_y), y);
        end
        apply(B_0);

        // skip over forbidden cells
        do_reset();
        apply(B_R); apply(B_0); apply(B_R); apply(B_0); apply(B_D); apply(B_0);
        chk_w("skip.pre", 2, 1, 0, 0);
        mask = m3;
        restr = 1'b1;
        apply(B_0);
        chk_w("skip.arm", 2, 1, 0, 0);
        apply(B_D);
        chk_w("skip.down", 2, 0, 1, 0);
        apply(B_0);
        mask[8] = 1'b1;
        apply(B_0);
        apply(B_D);
        chk_w("skip.blocked", 2, 0, 0, 1);
        apply(B_0);
        chk_w("skip.blk_end", 2, 0, 0, 0);

        // clamp at right edge
        restr = 1'b0;
        mask = '0;
        do_reset();
        for (int i = 0; i < 5; i++) begin apply(B_R); apply(B_0); end
        for (int i = 0; i < 2; i++) begin apply(B_D); apply(B_0); end
        chk("clamp.pre.x", int'(bc.pos_x), 5);
        chk("clamp.pre.y", int'(bc.pos_y), 2);
        apply(B_R);
        chk("clamp.x", int'(bc.pos_x), 5);
        chk("clamp.y", int'(bc.pos_y), 2);
        chk("clamp.val", int'(bc.val), 17);
        chk("clamp.blocked", int'(bc.blocked), 1);
        chk("clamp.moved", int'(bc.moved), 0);
        chk_w("clamp.wrapref", 0, 2, 1, 0);
        apply(B_0);
        chk("clamp.blk_end", int'(bc.blocked), 0);
        chk("clamp.hold_x", int'(bc.pos_x), 5);

        // snap when current cell becomes forbidden
        mask = m3;
        restr = 1'b0;
        do_reset();
        apply(B_R); apply(B_0); apply(B_R); apply(B_0); apply(B_R); apply(B_0);
        apply(B_U); apply(B_0);
        chk_w("snap.pre", 3, 3, 0, 0);
        restr = 1'b1;
        apply(B_0);
        chk_w("snap", 0, 0, 1, 0);
        apply(B_0);
        chk_w("snap.after", 0, 0, 0, 0);

        // snap beats a simultaneous step
        restr = 1'b0;
        apply(B_R); apply(B_0); apply(B_R); apply(B_0); apply(B_R); apply(B_0);
        apply(B_U); apply(B_0);
        chk_w("snapprio.pre", 3, 3, 0, 0);
        restr = 1'b1;
        apply(B_L);
        chk_w("snapprio", 0, 0, 1, 0);
        apply(B_0);
        restr = 1'b0;

        // multi-hot ignored, release to one-hot steps once
        do_reset();
        btn = B_U | B_L;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk_w($sformatf("multi.c%0d", c), 0, 0, 0, 0);
            chk($sformatf("multi.c%0d.state", c), int'(dut_w.u_rpt.state), int'(IDLE));
        end
        apply(B_U);
        chk_w("multi.release", 0, 3, 1, 0);
        apply(B_U);
        chk_w("multi.hold", 0, 3, 0, 0);
        apply(B_0);

        // reset while repeating, button still held
        do_reset();
        btn = B_R;
        for (int c = 0; c < 11; c++) cycle();
        chk("rpt.state", int'(dut_w.u_rpt.state), int'(RPT));
        chk("rpt.x", int'(bw.pos_x), 2);
        rst = 1'b0;
        cycle();
        cycle();
        chk_w("rpt.inreset", 0, 0, 0, 0);
        chk("rpt.inreset.state", int'(dut_w.u_rpt.state), int'(IDLE));
        rst = 1'b1;
        cycle();
        chk_w("rpt.release", 1, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk_w($sformatf("rpt.post%0d", c), 1, 0, 0, 0);
        end
        apply(B_0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
